wrr_grant_arbiter: RTL and testbench

- Parametrised weighted round-robin arbiter that generates its own rotating priority internally; no external next-grant input is needed.
- Each requestor has its own programmable weight, giving the number of consecutive cycles it may hold the grant.
- Supports early release when the holder drops its request, a plain round-robin mode, and a global enable.
- Sits in front of the shared resource; requestors hold request until served.

---
 rtl/wrr_grant_arbiter_if.sv | 30 +++
 rtl/wrr_grant_arbiter.sv | 142 ++++++++++++++
 tb/tb_wrr_grant_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wrr_grant_arbiter_if.sv
// rtl/wrr_grant_arbiter_if.sv - request/grant bundle between requestors and the WRR arbiter
//
// Purpose: groups the arbitration controls, request vector, per-channel
// weights and the registered grant outputs into one bundle.
//   master : requestor side; drives enable, rr_mode, request, weights
//   slave  : arbiter side; drives grant, grant_valid, grant_id, grant_last
interface wrr_grant_arbiter_if #(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 5,
   parameter int IDW      = $clog2(CHANNELS)
);
   logic                      enable;
   logic                      rr_mode;
   logic [CHANNELS-1:0]       request;
   logic [CHANNELS*WIDTH-1:0] weights;
   logic [CHANNELS-1:0]       grant;
   logic                      grant_valid;
   logic [IDW-1:0]            grant_id;
   logic                      grant_last;

   modport master (
      output enable, rr_mode, request, weights,
      input  grant, grant_valid, grant_id, grant_last
   );

   modport slave (
      input  enable, rr_mode, request, weights,
      output grant, grant_valid, grant_id, grant_last
   );
endinterface

// File: rtl/wrr_grant_arbiter.sv
// rtl/wrr_grant_arbiter.sv - weighted round-robin grant arbiter with internal rotating priority
//
// Purpose: grants one of CHANNELS requestors at a time. Each grant lasts
// min(weight, WEIGHTLIMIT) cycles (1 for weight 0 or in rr_mode), ends early
// when the holder drops its request, and hands over back-to-back to the next
// requestor found scanning upward from the channel after the last holder.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of wrr_grant_arbiter_if
//           enable      - 1 allows new grants
//           rr_mode     - 1 forces single-cycle grants
//           request     - level request per channel
//           weights     - packed weights, channel i at [i*WIDTH +: WIDTH]
//           grant       - registered one-hot (or zero) grant
//           grant_valid - grant is non-zero
//           grant_id    - index of granted channel, 0 when idle
//           grant_last  - final cycle of a full-length tenure
module wrr_grant_arbiter #(
   parameter int CHANNELS    = 8,
   parameter int WIDTH       = 5,
   parameter int WEIGHTLIMIT = 16,
   parameter int IDW         = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   wrr_grant_arbiter_if.slave  bus
);

   // Counter holds remaining cycles minus one, so it never exceeds WEIGHTLIMIT-1.
   localparam int CW = (WEIGHTLIMIT > 1) ? $clog2(WEIGHTLIMIT) : 1;
   localparam logic [31:0] WLIM = WEIGHTLIMIT;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state;
   logic [IDW-1:0]      ptr;
   logic [CW-1:0]       cnt;
   logic [CHANNELS-1:0] grant_q;
   logic [IDW-1:0]      id_q;

   logic [IDW-1:0]        next_ptr;
   logic [IDW-1:0]        scan_base;
   logic [2*CHANNELS-1:0] dbl_req;
   logic [2*CHANNELS-1:0] base_mask;
   logic [2*CHANNELS-1:0] masked;
   logic [2*CHANNELS-1:0] lowest;
   logic [CHANNELS-1:0]   win_onehot;
   logic [IDW-1:0]        win_id;
   logic [WIDTH-1:0]      win_weight;
   logic [CW-1:0]         cnt_load;
   logic                  release_now;
   logic                  want_new;

   always_comb begin
      next_ptr = (id_q == IDW'(CHANNELS - 1)) ? '0 : id_q + IDW'(1);
   end

   // On a release the scan must start after the outgoing holder in the same
   // edge that ptr is updated, so the new base is used directly.
   always_comb begin
      scan_base = (state == HOLD) ? next_ptr : ptr;
   end

   // Rotating priority: duplicate the request vector, clear everything below
   // the scan base in the lower copy, then isolate the lowest set bit. The
   // upper copy provides the wrap-around without any sequential scanning.
   always_comb begin
      dbl_req    = {bus.request, bus.request};
      base_mask  = ~(((2*CHANNELS)'(1) << scan_base) - (2*CHANNELS)'(1));
      masked     = dbl_req & base_mask;
      lowest     = masked & (~masked + (2*CHANNELS)'(1));
      win_onehot = lowest[CHANNELS-1:0] | lowest[2*CHANNELS-1:CHANNELS];
      win_id     = '0;
      for (int i = 0; i < 2*CHANNELS; i++) begin
         if (lowest[i]) begin
            win_id = win_id | IDW'(i % CHANNELS);
         end
      end
   end

   // Tenure length is captured only when the grant is issued.
   always_comb begin
      win_weight = bus.weights[int'(win_id)*WIDTH +: WIDTH];
      if (bus.rr_mode || (win_weight == '0)) begin
         cnt_load = '0;
      end else if (32'(win_weight) > WLIM) begin
         cnt_load = CW'(WLIM - 32'd1);
      end else begin
         cnt_load = CW'(32'(win_weight) - 32'd1);
      end
   end

   always_comb begin
      release_now = (cnt == '0) || !bus.request[id_q];
      want_new    = bus.enable && (bus.request != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         grant_q <= '0;
         id_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (want_new) begin
                  state   <= HOLD;
                  grant_q <= win_onehot;
                  id_q    <= win_id;
                  cnt     <= cnt_load;
               end
            end
            HOLD: begin
               if (release_now) begin
                  ptr <= next_ptr;
                  if (want_new) begin
                     grant_q <= win_onehot;
                     id_q    <= win_id;
                     cnt     <= cnt_load;
                  end else begin
                     state   <= IDLE;
                     grant_q <= '0;
                     id_q    <= '0;
                     cnt     <= '0;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = (state == HOLD);
   assign bus.grant_id    = id_q;
   assign bus.grant_last  = (state == HOLD) && (cnt == '0);

endmodule

// File: tb/tb_wrr_grant_arbiter.sv
// tb/tb_wrr_grant_arbiter.sv - self-checking bench for wrr_grant_arbiter
module tb_wrr_grant_arbiter;
   localparam int CH  = 8;
   localparam int W   = 5;
   localparam int WL  = 16;
   localparam int IDW = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wrr_grant_arbiter_if #(.CHANNELS(CH), .WIDTH(W), .IDW(IDW)) bus ();

   wrr_grant_arbiter #(.CHANNELS(CH), .WIDTH(W), .WEIGHTLIMIT(WL), .IDW(IDW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: current holder (-1 idle), cycles left in tenure
   // including the present one, and the channel the next scan starts from.
   int m_holder = -1;
   int m_left   = 0;
   int m_ptr    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic m_issue(input int p);
      int ch;
      int w;
      ch = p;
      for (int i = 0; i < CH; i++) begin
         ch = (p + i) % CH;
         if (bus.request[ch]) break;
      end
      w = int'(bus.weights[ch*W +: W]);
      m_holder = ch;
      if (bus.rr_mode || w == 0) m_left = 1;
      else if (w > WL)           m_left = WL;
      else                       m_left = w;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_holder = -1;
         m_left   = 0;
         m_ptr    = 0;
      end else if (m_holder < 0) begin
         if (bus.enable && bus.request != 0) m_issue(m_ptr);
      end else if (m_left == 1 || !bus.request[m_holder]) begin
         m_ptr = (m_holder + 1) % CH;
         if (bus.enable && bus.request != 0) m_issue(m_ptr);
         else begin
            m_holder = -1;
            m_left   = 0;
         end
      end else begin
         m_left--;
      end
   end

   logic [CH-1:0] exp_grant;
   always @(negedge clk) begin
      exp_grant = (m_holder >= 0) ? (CH'(1) << m_holder) : '0;
      chk("grant",       32'(bus.grant),       32'(exp_grant));
      chk("grant_valid", 32'(bus.grant_valid), (m_holder >= 0) ? 32'd1 : 32'd0);
      chk("grant_id",    32'(bus.grant_id),    (m_holder >= 0) ? 32'(m_holder) : 32'd0);
      chk("grant_last",  32'(bus.grant_last),  (m_holder >= 0 && m_left == 1) ? 32'd1 : 32'd0);
      chk("onehot0",     32'($countones(bus.grant) <= 1), 32'd1);
   end

   task automatic set_w(input int ch, input int val);
      bus.weights[ch*W +: W] = W'(val);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   int rot_id[10]   = '{0, 0, 0, 2, 2, 0, 0, 0, 2, 2};
   int rot_last[10] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
   logic [63:0] r64;

   initial begin
      bus.enable  = 1'b1;
      bus.rr_mode = 1'b0;
      bus.request = 8'hFF;
      bus.weights = '0;
      for (int c = 0; c < CH; c++) set_w(c, 1);

      // Reset held two cycles with all channels requesting.
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_grant", 32'(bus.grant), 32'd0);
         chk("rst_valid", 32'(bus.grant_valid), 32'd0);
         chk("rst_id",    32'(bus.grant_id), 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("first_id",    32'(bus.grant_id), 32'd0);
      chk("first_valid", 32'(bus.grant_valid), 32'd1);

      // Weighted rotation: ch0 weight 3, ch2 weight 2.
      bus.request = 8'h05;
      set_w(0, 3);
      set_w(2, 2);
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rot_id",   32'(bus.grant_id),   32'(rot_id[i]));
         chk("rot_last", 32'(bus.grant_last), 32'(rot_last[i]));
      end

      // Clamp to WEIGHTLIMIT and zero-weight to one cycle.
      bus.request = 8'h0A;
      set_w(1, 31);
      set_w(3, 0);
      pulse_reset();
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         chk("clamp_id",   32'(bus.grant_id), (i % 17 == 16) ? 32'd3 : 32'd1);
         chk("clamp_last", 32'(bus.grant_last), (i % 17 >= 15) ? 32'd1 : 32'd0);
      end

      // Early release: ch4 weight 8 drops request in its third cycle.
      bus.request = 8'h50;
      set_w(4, 8);
      set_w(6, 1);
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("early_id",   32'(bus.grant_id), 32'd4);
         chk("early_last", 32'(bus.grant_last), 32'd0);
      end
      bus.request = 8'h40;
      @(negedge clk);
      chk("early_next", 32'(bus.grant_id), 32'd6);

      // Plain round robin.
      bus.rr_mode = 1'b1;
      bus.request = 8'hFF;
      for (int c = 0; c < CH; c++) set_w(c, 7);
      pulse_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("rr_id",    32'(bus.grant_id), 32'(i % 8));
         chk("rr_valid", 32'(bus.grant_valid), 32'd1);
      end

      // Enable drop during a tenure, then reset mid-tenure.
      bus.rr_mode = 1'b0;
      for (int c = 0; c < CH; c++) set_w(c, 1);
      set_w(2, 4);
      set_w(5, 4);
      bus.request = 8'h04;
      pulse_reset();
      @(negedge clk);
      chk("en_id1", 32'(bus.grant_id), 32'd2);
      bus.enable  = 1'b0;
      bus.request = 8'h24;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("en_hold", 32'(bus.grant_id), 32'd2);
      end
      chk("en_last", 32'(bus.grant_last), 32'd1);
      repeat (2) begin
         @(negedge clk);
         chk("en_off_grant", 32'(bus.grant), 32'd0);
      end
      bus.enable = 1'b1;
      @(negedge clk);
      chk("en_resume", 32'(bus.grant_id), 32'd5);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_grant", 32'(bus.grant), 32'd0);
      chk("mid_rst_valid", 32'(bus.grant_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_ptr", 32'(bus.grant_id), 32'd2);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom % 4 == 0) bus.request = CH'($urandom);
         bus.enable  = ($urandom % 8) != 0;
         bus.rr_mode = ($urandom % 10) == 0;
         if ($urandom % 3 == 0) begin
            r64 = {$urandom, $urandom};
            bus.weights = r64[CH*W-1:0];
         end
         reset = ($urandom % 300) == 0;
      end
      reset = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
